// File: rtl/entity_update_scheduler.sv
// entity_update_scheduler: walks an Avalon-written entity bitmap per frame and issues one valid/ready update per active slot
// Ports: clk/reset (async, active-high); Avalon-MM slave address/write/writedata/readdata (1-cycle read latency);
// frame_tick starts a frame when auto is set; upd_valid/upd_id/upd_ready carry update requests;
// busy reports a frame in progress; irq = done & irq_en.
module entity_update_scheduler #(
  parameter int NUM_ENTITIES = 16,
  parameter int ID_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      address,
  input  logic            write,
  input  logic [31:0]     writedata,
  output logic [31:0]     readdata,
  input  logic            frame_tick,
  output logic            upd_valid,
  output logic [ID_W-1:0] upd_id,
  input  logic            upd_ready,
  output logic            busy,
  output logic            irq
);
  typedef enum logic [1:0] {IDLE, SCAN, ISSUE, DONE} state_t;
  state_t r_state, w_next;
  logic [NUM_ENTITIES-1:0] r_mask, r_snap;
  logic [5:0] r_idx, r_cnt, r_last;
  logic r_irq_en, r_auto, r_done, r_aborted, r_abort_pend;
  logic w_ctrl_wr, w_stat_wr, w_start, w_abort, w_hit, w_last_slot;
  logic [63:0] w_snap_ext;
  logic [31:0] w_rd;
  logic w_unused;
  assign w_unused    = &{1'b0, writedata};
  assign w_ctrl_wr   = write && address == 2'd1;
  assign w_stat_wr   = write && address == 2'd2;
  assign w_start     = (w_ctrl_wr && writedata[0]) || (r_auto && frame_tick);
  assign w_abort     = w_ctrl_wr && writedata[1];
  // zero-extended so the 6-bit index never selects outside the vector
  assign w_snap_ext  = 64'(r_snap);
  assign w_hit       = w_snap_ext[r_idx];
  // leaving the final slot goes straight to DONE so no extra scan cycle is spent past the end
  assign w_last_slot = r_idx >= 6'(NUM_ENTITIES - 1);
  assign busy        = r_state != IDLE;
  assign upd_valid   = r_state == ISSUE;
  assign upd_id      = ID_W'(r_idx);
  assign irq         = r_done & r_irq_en;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_start ? SCAN : IDLE;
      SCAN:    w_next = r_abort_pend ? IDLE : w_hit ? ISSUE : w_last_slot ? DONE : SCAN;
      // a pending abort must pass through SCAN, so it never completes as DONE
      ISSUE:   w_next = !upd_ready ? ISSUE : (w_last_slot && !r_abort_pend) ? DONE : SCAN;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    w_rd = address == 2'd0 ? 32'(r_mask) :
           address == 2'd1 ? {28'd0, r_auto, r_irq_en, 1'b0, busy} :
           address == 2'd2 ? {18'd0, r_last, 6'd0, r_aborted, r_done} :
                             {busy, 31'(upd_id)};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      readdata     <= '0;
      r_mask       <= '0;
      r_snap       <= '0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_last       <= '0;
      r_irq_en     <= 1'b0;
      r_auto       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      r_state  <= w_next;
      readdata <= w_rd;
      if (write && address == 2'd0) r_mask <= writedata[NUM_ENTITIES-1:0];
      if (w_ctrl_wr) begin
        r_irq_en <= writedata[2];
        r_auto   <= writedata[3];
      end
      // aborts are dropped in IDLE and consumed by the first SCAN that sees them
      r_abort_pend <= (r_state == IDLE || (r_state == SCAN && r_abort_pend)) ? 1'b0 : r_abort_pend | w_abort;
      if (r_state == IDLE && w_start) begin
        r_snap <= r_mask;
        r_idx  <= '0;
        r_cnt  <= '0;
      end
      if (r_state == SCAN && !r_abort_pend && !w_hit) r_idx <= r_idx + 6'd1;
      if (r_state == ISSUE && upd_ready) begin
        r_idx <= r_idx + 6'd1;
        r_cnt <= r_cnt + 6'd1;
      end
      if (r_state == DONE) r_last <= r_cnt;
      // hardware set has priority over a same-cycle W1C
      r_done    <= (r_state == DONE) | (r_done & ~(w_stat_wr & writedata[0]));
      r_aborted <= (r_state == SCAN && r_abort_pend) | (r_aborted & ~(w_stat_wr & writedata[1]));
    end
  end
endmodule

// File: tb/tb_entity_update_scheduler.sv
// tb_entity_update_scheduler: directed frames checked against a queue model of expected update ids and frame costs
module tb_entity_update_scheduler;
  localparam int N = 16;
  logic clk = 0, reset = 1;
  logic [1:0] address = 0;
  logic write = 0;
  logic [31:0] writedata = 0;
  logic [31:0] readdata;
  logic frame_tick = 0;
  logic upd_valid;
  logic [4:0] upd_id;
  logic upd_ready = 1;
  logic busy, irq;
  int n_cmp = 0, n_fail = 0;
  int exp_q[$];
  int valid_cnt[32];
  int busy_cyc = 0, runs = 0;
  logic prev_busy = 0, prev_stall = 0;
  logic [4:0] prev_id = 0;

  always #5 clk = ~clk;

  entity_update_scheduler #(.NUM_ENTITIES(N), .ID_W(5)) dut (
    .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
    .readdata(readdata), .frame_tick(frame_tick), .upd_valid(upd_valid), .upd_id(upd_id),
    .upd_ready(upd_ready), .busy(busy), .irq(irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (busy) busy_cyc++;
      if (busy && !prev_busy) runs++;
      prev_busy = busy;
      if (prev_stall) chk("hold", {26'd0, upd_valid, upd_id}, {26'd0, 1'b1, prev_id});
      if (upd_valid) begin
        if (exp_q.size() == 0) chk("unexpected_id", {27'd0, upd_id}, 32'hFFFF_FFFF);
        else chk("upd_id", {27'd0, upd_id}, exp_q[0]);
        valid_cnt[upd_id]++;
        if (upd_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      prev_stall = upd_valid && !upd_ready;
      prev_id = upd_id;
    end
  end

  function automatic void load(input logic [31:0] m);
    exp_q.delete();
    for (int i = 0; i < N; i++) if (m[i]) exp_q.push_back(i);
    for (int i = 0; i < 32; i++) valid_cnt[i] = 0;
    busy_cyc = 0;
  endfunction

  function automatic int frame_cost(input logic [31:0] m, input int stalls);
    logic [N-1:0] v;
    v = m[N-1:0];
    return N + $countones(v) + stalls + 1;
  endfunction

  task automatic check_counts(input logic [31:0] m, input int sid, input int sval);
    for (int i = 0; i < N; i++) chk($sformatf("valid_cycles[%0d]", i), valid_cnt[i], (i == sid) ? sval : (m[i] ? 1 : 0));
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    address = a; write = 1; writedata = d;
    @(posedge clk); #1;
    write = 0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    address = a;
    @(posedge clk); #1;
    d = readdata;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (busy && k < budget);
    chk("idle_timeout", {31'd0, busy}, 0);
  endtask

  task automatic wait_valid(input int id, input int budget);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (!(upd_valid && upd_id == 5'(id)) && k < budget);
    chk("valid_timeout", {26'd0, upd_valid, upd_id}, {26'd0, 1'b1, 5'(id)});
  endtask

  initial begin
    logic [31:0] d;
    int r0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rst_valid", {31'd0, upd_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_irq", {31'd0, irq}, 0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      chk($sformatf("rst_reg%0d", a), d, 0);
    end
    // sparse mask, ready tied high
    wr(0, 32'h8421);
    wr(1, 32'h4);
    load(32'h8421);
    wr(1, 32'h5);
    wait_idle(200);
    chk("t1_busy_cycles", busy_cyc, 21);
    chk("t1_busy_model", busy_cyc, frame_cost(32'h8421, 0));
    check_counts(32'h8421, -1, 0);
    chk("t1_q_empty", exp_q.size(), 0);
    rd(2, d);
    chk("t1_status", d, 32'h401);
    chk("t1_irq", {31'd0, irq}, 1);
    rd(3, d);
    chk("t1_current", d, 32'h10);
    wr(2, 32'h1);
    chk("t1_irq_clr", {31'd0, irq}, 0);
    rd(2, d);
    chk("t1_status_clr", d, 32'h400);
    // full mask, 3-cycle stall on id 2
    wr(0, 32'hFFFF);
    load(32'hFFFF);
    wr(1, 32'h5);
    wait_valid(1, 100);
    @(posedge clk); #1 upd_ready = 0;
    wait_valid(2, 50);
    repeat (3) @(posedge clk);
    #1 upd_ready = 1;
    wait_idle(200);
    chk("t2_busy_cycles", busy_cyc, frame_cost(32'hFFFF, 3));
    check_counts(32'hFFFF, 2, 4);
    chk("t2_q_empty", exp_q.size(), 0);
    rd(2, d);
    chk("t2_status", d, 32'h1001);
    wr(2, 32'h3);
    // snapshot isolation and start-while-busy
    wr(0, 32'h3);
    load(32'h3);
    r0 = runs;
    wr(1, 32'h5);
    wr(0, 32'hFFFF);
    wr(1, 32'h5);
    wait_idle(200);
    chk("t3_runs", runs - r0, 1);
    chk("t3_busy_cycles", busy_cyc, 19);
    check_counts(32'h3, -1, 0);
    chk("t3_q_empty", exp_q.size(), 0);
    rd(2, d);
    chk("t3_status", d, 32'h201);
    wr(2, 32'h3);
    wr(1, 32'hC);
    load(32'hFFFF);
    r0 = runs;
    @(posedge clk); #1 frame_tick = 1;
    @(posedge clk); #1 frame_tick = 0;
    wait_idle(200);
    chk("t3_auto_runs", runs - r0, 1);
    chk("t3_auto_busy", busy_cyc, 33);
    check_counts(32'hFFFF, -1, 0);
    rd(2, d);
    chk("t3_auto_status", d, 32'h1001);
    wr(2, 32'h3);
    // abort while id 3 is stalled
    load(32'hFFFF);
    wr(1, 32'hD);
    wait_valid(2, 100);
    @(posedge clk); #1 upd_ready = 0;
    wait_valid(3, 50);
    wr(1, 32'hE);
    upd_ready = 1;
    wait_idle(100);
    chk("t4_q_left", exp_q.size(), 12);
    chk("t4_q_head", exp_q.size() != 0 ? exp_q[0] : -1, 4);
    for (int i = 0; i < 3; i++) chk($sformatf("t4_valid[%0d]", i), valid_cnt[i], 1);
    for (int i = 4; i < N; i++) chk($sformatf("t4_valid[%0d]", i), valid_cnt[i], 0);
    rd(2, d);
    chk("t4_status", d, 32'h1002);
    chk("t4_irq", {31'd0, irq}, 0);
    rd(1, d);
    chk("t4_ctrl", d, 32'hC);
    wr(2, 32'h3);
    // empty mask, then start and tick together
    wr(0, 32'h0);
    load(32'h0);
    wr(1, 32'hD);
    wait_idle(100);
    chk("t5_busy_cycles", busy_cyc, 17);
    rd(2, d);
    chk("t5_status", d, 32'h1);
    wr(2, 32'h3);
    wr(0, 32'h11);
    load(32'h11);
    r0 = runs;
    @(posedge clk); #1;
    address = 1; write = 1; writedata = 32'hD; frame_tick = 1;
    @(posedge clk); #1;
    write = 0; frame_tick = 0;
    wait_idle(100);
    chk("t5_runs", runs - r0, 1);
    chk("t5_busy_cycles", busy_cyc, frame_cost(32'h11, 0));
    check_counts(32'h11, -1, 0);
    rd(2, d);
    chk("t5_status2", d, 32'h201);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
